// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring 32-bit divider (DIV/DIVU) for the EX stage
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   signed_div_i : 1 = signed DIV, 0 = DIVU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held high until the result is consumed
//   annul_i      : abort the operation in progress
//   result_o     : {remainder, quotient}
//   ready_o      : result_o valid
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_dividend;
  logic [DATA_W-1:0]   r_divisor;
  logic [DATA_W-1:0]   r_rem;
  logic                r_signed;
  logic                r_s1;
  logic                r_s2;
  logic [DATA_W-1:0]   w_abs1;
  logic [DATA_W-1:0]   w_abs2;
  logic [DATA_W:0]     w_trial;
  logic                w_ge;
  logic [DATA_W-1:0]   w_diff;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  always_comb begin
    w_abs1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    w_abs2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // next dividend bit enters the partial remainder MSB first; quotient bits
    // shift into the vacated low end of r_dividend
    w_trial   = {r_rem, r_dividend[DATA_W-1]};
    w_ge      = w_trial >= {1'b0, r_divisor};
    // when w_ge holds the difference is below the divisor, so the low bits are exact
    w_diff    = w_trial[DATA_W-1:0] - r_divisor;
    w_quo_fix = (r_signed && (r_s1 ^ r_s2)) ? -r_dividend : r_dividend;
    w_rem_fix = (r_signed && r_s1) ? -r_rem : r_rem;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FREE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_signed   <= 1'b0;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      case (r_state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= BYZERO;
            end else begin
              r_state    <= ON;
              r_dividend <= w_abs1;
              r_divisor  <= w_abs2;
              r_cnt      <= '0;
              r_rem      <= '0;
              r_signed   <= signed_div_i;
              r_s1       <= opdata1_i[DATA_W-1];
              r_s2       <= opdata2_i[DATA_W-1];
            end
          end
        end
        // divide-by-zero result is zero; ready is raised one cycle later from END
        BYZERO: begin
          r_state  <= annul_i ? FREE : END;
          result_o <= '0;
          ready_o  <= 1'b0;
        end
        ON: begin
          if (annul_i) begin
            r_state  <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (r_cnt == CNT_W'(DATA_W)) begin
            r_state  <= END;
            result_o <= {w_rem_fix, w_quo_fix};
            ready_o  <= 1'b1;
          end else begin
            r_rem      <= w_ge ? w_diff : w_trial[DATA_W-1:0];
            r_dividend <= {r_dividend[DATA_W-2:0], w_ge};
            r_cnt      <= r_cnt + 1'b1;
          end
        end
        END: begin
          if (start_i) begin
            ready_o <= 1'b1;
          end else begin
            r_state  <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven self-checking bench for div_unit with a result scoreboard
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[10];
  logic [63:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk),
    .rst(rst),
    .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i),
    .start_i(start_i),
    .annul_i(annul_i),
    .result_o(result_o),
    .ready_o(ready_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp);
    int          k;
    int          lat;
    logic [63:0] e;
    lat = (b == 0) ? 2 : 33;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    chk("ready_at_e0", {63'd0, ready_o}, 64'd0);
    signed_div_i = $urandom_range(0, 1);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!ready_o && k < 100);
    chk("latency", 64'(k), 64'(lat));
    e = sb.pop_front();
    chk("result", result_o, e);
  endtask

  task automatic drop();
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_ready", {63'd0, ready_o}, 64'd0);
    chk("drop_result", result_o, 64'd0);
  endtask

  initial begin
    bit          seen;
    logic [63:0] held;
    vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'h2,        32'hE}};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0,        32'h80000000}};
    vecs[3] = '{1'b0, 32'hFFFFFFFF,   32'h1,        {32'h0,        32'hFFFFFFFF}};
    vecs[4] = '{1'b1, 32'hFFFFFFFF,   32'h1,        {32'h0,        32'hFFFFFFFF}};
    vecs[5] = '{1'b0, 32'h1234,       32'h0,        64'h0};
    vecs[6] = '{1'b1, 32'h7,          32'hFFFFFFFE, {32'h1,        32'hFFFFFFFD}};
    vecs[7] = '{1'b0, 32'hFFFFFFF9,   32'h2,        {32'h1,        32'h7FFFFFFC}};
    vecs[8] = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD, {32'hFFFFFFFE, 32'h2}};
    vecs[9] = '{1'b0, 32'h5,          32'h9,        {32'h5,        32'h0}};
    #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);
      drop();
    end
    // divide by zero: outputs must stay stable while start is held
    run(1'b1, 32'hDEAD, 32'h0, 64'h0);
    seen = 1'b0;
    held = result_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (!ready_o || result_o !== held) seen = 1'b1;
    end
    chk("byzero_hold", {63'd0, seen}, 64'd0);
    drop();
    // start together with annul in FREE never launches an operation
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    chk("start_annul_free", {63'd0, seen}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    // annul at the 10th iteration returns to FREE with no result
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      if (ready_o) seen = 1'b1;
    end
    chk("annul_no_ready", {63'd0, seen}, 64'd0);
    run(1'b0, 32'd25, 32'd5, {32'h0, 32'h5});
    drop();
    // asynchronous reset mid-iteration
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_ready", {63'd0, ready_o}, 64'd0);
    chk("async_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run(1'b0, 32'd9, 32'd4, {32'h1, 32'h2});
    // asynchronous reset while a result is being held clears it at once
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_end_ready", {63'd0, ready_o}, 64'd0);
    chk("async_rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
